// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - shared funct3 codes, FSM states and lane masks for the data-memory LSU
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] LANES_B = 4'b0001;
  localparam logic [3:0] LANES_H = 4'b0011;
  localparam logic [3:0] LANES_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Unsigned-extension codes exist only for loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return |off;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// rtl/dmem_lsu_align.sv - byte-lane steering for stores and extraction/extension for loads
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] drdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    be         = LANES_W;
    lane_wdata = wdata;
    load_data  = 32'd0;
    shifted    = drdata >> {off, 3'b000};

    // Replicating the datum lets the lane mask alone pick the destination bytes.
    case (funct3[1:0])
      2'b00: begin
        be         = LANES_B << off;
        lane_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = LANES_H << off;
        lane_wdata = {2{wdata[15:0]}};
      end
      default: begin
        be         = LANES_W;
        lane_wdata = wdata;
      end
    endcase

    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - single-outstanding load/store initiator for the byte-banked data memory
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned DMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

  localparam logic [32:0] LIMIT = 33'(DMEM_WORDS) << 2;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] rel_addr;
  logic        req_bad;
  logic [3:0]  be;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;

  // Wrapping subtraction makes addresses below BASE_ADDR land far out of range.
  assign rel_addr = req_addr - BASE_ADDR;
  assign req_bad  = f3_illegal(req_funct3, req_we)
                  | f3_misaligned(req_funct3, req_addr[1:0])
                  | ({1'b0, rel_addr} >= LIMIT);

  dmem_lsu_align u_align (
    .funct3     (f3_q),
    .off        (addr_q[1:0]),
    .wdata      (wdata_q),
    .drdata     (drdata),
    .be         (be),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    daddr     = 32'd0;
    dwdata    = 32'd0;
    dwe       = 4'd0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_bad) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // dwe is decoded from state so an async reset kills the write strobe at once.
        daddr   = {addr_q[31:2], 2'b00};
        err_d   = 1'b0;
        state_d = ST_RESP;
        if (we_q) begin
          dwe     = be;
          dwdata  = lane_wdata;
          rdata_d = 32'd0;
        end else begin
          rdata_d = load_data;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - randomized and directed bench for dmem_lsu against a byte-level memory model
module tb_dmem_lsu;

  localparam int WORDS = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, daddr, dwdata, drdata;
  logic [3:0]  dwe;

  always #5 clk = ~clk;

  dmem_lsu #(.BASE_ADDR(32'h0), .DMEM_WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
  );

  logic [31:0] mem [WORDS];
  logic [7:0]  ref_mem [WORDS*4];

  assign drdata = mem[daddr[13:2]];

  always @(posedge clk)
    for (int l = 0; l < 4; l++)
      if (dwe[l]) mem[daddr[13:2]][8*l +: 8] <= dwdata[8*l +: 8];

  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0;
  int acc_cnt = 0, acc_edge = 0, rsp_cnt = 0, store_seen = 0, last_lat = 0;
  logic [31:0] last_rdata, last_daddr, last_dwdata;
  logic        last_err;
  logic [3:0]  last_dwe;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle expectations, indexed by the number of rising edges seen modulo 16.
  bit          e_ready [16];
  bit          e_rv    [16];
  bit          e_err   [16];
  bit          e_chkwd [16];
  logic [31:0] e_rdata [16];
  logic [31:0] e_daddr [16];
  logic [31:0] e_dwdata[16];
  logic [3:0]  e_dwe   [16];
  bit          s_v     [16];
  logic [31:0] s_addr  [16];
  logic [31:0] s_wdata [16];
  int          s_n     [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
  endtask

  function automatic void clear_slot(input int s);
    e_ready[s] = 1'b1; e_rv[s] = 1'b0; e_err[s] = 1'b0; e_chkwd[s] = 1'b1;
    e_rdata[s] = 32'd0; e_daddr[s] = 32'd0; e_dwdata[s] = 32'd0; e_dwe[s] = 4'd0;
    s_v[s] = 1'b0; s_addr[s] = 32'd0; s_wdata[s] = 32'd0; s_n[s] = 0;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    if (we && f3[2]) return 1'b1;
    if ((a % 32'(nbytes(f3))) != 0) return 1'b1;
    if (longint'(a) >= longint'(4 * WORDS)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = 32'd0;
    n = nbytes(f3);
    for (int i = 0; i < n; i++) v |= 32'(ref_mem[int'(a[13:0]) + i]) << (8 * i);
    if (!f3[2] && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  always @(negedge clk) begin : cmp
    int s, e, s0, s1, n, off;
    logic [3:0] mask;
    logic [31:0] rep;
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) clear_slot(k);
    end else begin
      s = cyc % 16;
      chk("req_ready", 32'(req_ready), 32'(e_ready[s]));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv[s]));
      if (e_rv[s]) begin
        chk("rsp_rdata", rsp_rdata, e_rdata[s]);
        chk("rsp_err", 32'(rsp_err), 32'(e_err[s]));
      end
      chk("dwe", 32'(dwe), 32'(e_dwe[s]));
      chk("daddr", daddr, e_daddr[s]);
      if (e_chkwd[s]) chk("dwdata", dwdata, e_dwdata[s]);
      if (s_v[s])
        for (int i = 0; i < s_n[s]; i++)
          ref_mem[int'(s_addr[s][13:0]) + i] = s_wdata[s][8*i +: 8];
      clear_slot(s);

      if (rsp_valid) begin
        rsp_cnt++;
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        last_lat   = cyc - acc_edge;
      end
      if (dwe != 4'd0) begin
        store_seen++;
        last_dwe    = dwe;
        last_daddr  = daddr;
        last_dwdata = dwdata;
      end

      if (req_valid && req_ready) begin
        e  = cyc + 1;
        s0 = e % 16;
        s1 = (e + 1) % 16;
        acc_cnt++;
        acc_edge = e;
        e_ready[s0] = 1'b0;
        if (m_err(req_we, req_funct3, req_addr)) begin
          e_rv[s0] = 1'b1; e_err[s0] = 1'b1; e_rdata[s0] = 32'd0;
        end else begin
          n   = nbytes(req_funct3);
          off = int'(req_addr[1:0]);
          e_daddr[s0] = {req_addr[31:2], 2'b00};
          if (req_we) begin
            mask = 4'd0;
            for (int i = 0; i < n; i++) mask[off + i] = 1'b1;
            for (int l = 0; l < 4; l++) rep[8*l +: 8] = req_wdata[8*(l % n) +: 8];
            e_dwe[s0] = mask; e_dwdata[s0] = rep;
            s_v[s0] = 1'b1; s_addr[s0] = req_addr; s_wdata[s0] = req_wdata; s_n[s0] = n;
          end else begin
            e_chkwd[s0] = 1'b0;
          end
          e_ready[s1] = 1'b0;
          e_rv[s1]    = 1'b1;
          e_err[s1]   = 1'b0;
          e_rdata[s1] = req_we ? 32'd0 : m_load(req_funct3, req_addr);
        end
      end
    end
  end

  task automatic timeout(input string name);
    total_cnt++;
    $display("FAIL timeout_%s: no handshake within bound, got none expected one", name);
  endtask

  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit wait_rsp);
    int a0, r0;
    bit ok;
    a0 = acc_cnt;
    r0 = rsp_cnt;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      if (acc_cnt != a0) ok = 1'b1;
    end
    #1;
    if (!ok) timeout("accept");
    if (wait_rsp) begin
      req_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
        @(posedge clk);
        if (rsp_cnt != r0) ok = 1'b1;
      end
      #1;
      if (!ok) timeout("response");
    end
  endtask

  initial begin
    int first_edge, seen0, rsp0, bad;
    logic [31:0] a, v;
    logic [31:0] err_addr [4];
    logic [2:0]  err_f3   [4];
    bit          err_we   [4];

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int w = 0; w < WORDS; w++) begin
      v = $urandom;
      mem[w] = v;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = v[8*b +: 8];
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_dwe", 32'(dwe), 32'd0);
    chk("reset_daddr", daddr, 32'd0);
    rst_n = 1'b1;

    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1);
    chk("sw_daddr", last_daddr, 32'h10);
    chk("sw_dwe", 32'(last_dwe), 32'hF);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    chk("lw_rdata", last_rdata, 32'hDEADBEEF);
    chk("lw_err", 32'(last_err), 32'd0);
    chk("lw_latency", last_lat, 32'd1);

    issue(1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b1);
    chk("sb_dwe", 32'(last_dwe), 32'h8);
    chk("sb_dwdata", last_dwdata, 32'hA5A5A5A5);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b1);
    chk("lb_rdata", last_rdata, 32'hFFFFFFA5);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b1);
    chk("lbu_rdata", last_rdata, 32'h000000A5);

    issue(1'b1, 3'b001, 32'h22, 32'h00008001, 1'b1);
    chk("sh_dwe", 32'(last_dwe), 32'hC);
    issue(1'b0, 3'b001, 32'h22, 32'h0, 1'b1);
    chk("lh_rdata", last_rdata, 32'hFFFF8001);
    issue(1'b0, 3'b101, 32'h22, 32'h0, 1'b1);
    chk("lhu_rdata", last_rdata, 32'h00008001);

    err_we[0] = 1'b0; err_f3[0] = 3'b010; err_addr[0] = 32'h06;
    err_we[1] = 1'b0; err_f3[1] = 3'b001; err_addr[1] = 32'h03;
    err_we[2] = 1'b1; err_f3[2] = 3'b010; err_addr[2] = 32'h4000;
    err_we[3] = 1'b0; err_f3[3] = 3'b011; err_addr[3] = 32'h10;
    for (int k = 0; k < 4; k++) begin
      seen0 = store_seen;
      issue(err_we[k], err_f3[k], err_addr[k], 32'h55AA55AA, 1'b1);
      chk("err_flag", 32'(last_err), 32'd1);
      chk("err_latency", last_lat, 32'd0);
      chk("err_no_write", store_seen, seen0);
    end

    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    first_edge = acc_edge;
    issue(1'b0, 3'b010, 32'h14, 32'h0, 1'b0);
    chk("b2b_spacing", acc_edge - first_edge, 32'd3);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    issue(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 1'b1);
    seen0 = store_seen;
    rsp0  = rsp_cnt;
    issue(1'b1, 3'b010, 32'h40, 32'h12345678, 1'b0);
    req_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_dwe", 32'(dwe), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_write", store_seen, seen0);
    chk("abort_no_rsp", rsp_cnt, rsp0);
    issue(1'b0, 3'b010, 32'h40, 32'h0, 1'b1);
    chk("abort_mem_kept", last_rdata, 32'hCAFEF00D);

    for (int t = 0; t < 300; t++) begin
      case ($urandom % 10)
        8:       a = 32'h3FF8 + ($urandom % 16);
        9:       a = $urandom;
        default: a = $urandom % 64;
      endcase
      issue(1'($urandom % 2), 3'($urandom % 8), a, $urandom, ($urandom % 4) == 0);
    end
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    bad = 0;
    for (int w = 0; w < WORDS; w++)
      if (mem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) bad++;
    chk("mem_image_mismatches", bad, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
